// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle tying the naive_mips instruction and data buses, the bus arbiter
// and the single-ported memory/MMIO slave together.
interface mem_bus_arbiter_if;
  logic [31:0] ibus_address;
  logic [3:0]  ibus_byteenable;
  logic        ibus_read;
  logic        ibus_write;
  logic [31:0] ibus_wrdata;
  logic [31:0] ibus_rddata;
  logic        ibus_stall;
  logic        ibus_error;

  logic [31:0] dbus_address;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_wrdata;
  logic [31:0] dbus_rddata;
  logic        dbus_stall;
  logic        dbus_error;

  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wrdata;
  logic [31:0] mem_rddata;
  logic        mem_ack;

  // slave: the arbiter, which serves both core buses and drives the memory strobes.
  modport slave (
    input  ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
    output ibus_rddata, ibus_stall, ibus_error,
    input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
    output dbus_rddata, dbus_stall, dbus_error,
    output mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
    input  mem_rddata, mem_ack
  );

  // master: everything around the arbiter (the two core buses and the memory fabric).
  modport master (
    output ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
    input  ibus_rddata, ibus_stall, ibus_error,
    output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
    input  dbus_rddata, dbus_stall, dbus_error,
    input  mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
    output mem_rddata, mem_ack
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises naive_mips ibus/dbus requests onto one registered req/ack slave port,
// alternating on contention and turning a hung slave into an error completion.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  // One slave access as it is presented on the mem_* pins.
  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] wrdata;
    logic        read;
    logic        write;
  } mem_cmd_t;

  // Per-master response state; done and error are single-cycle completion pulses.
  typedef struct packed {
    logic [31:0] rddata;
    logic        done;
    logic        error;
  } resp_t;

  state_t           state_q, state_d;
  grant_t           last_q, last_d;
  mem_cmd_t         mem_q, mem_d;
  resp_t            ibus_q, ibus_d;
  resp_t            dbus_q, dbus_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic     ibus_pending, dbus_pending;
  mem_cmd_t ibus_cmd, dbus_cmd;

  assign ibus_pending = bus.ibus_read | bus.ibus_write;
  assign dbus_pending = bus.dbus_read | bus.dbus_write;

  // Read and write together is a write, so read is only asserted on its own.
  assign ibus_cmd = '{address:    bus.ibus_address,
                      byteenable: bus.ibus_byteenable,
                      wrdata:     bus.ibus_wrdata,
                      read:       bus.ibus_read & ~bus.ibus_write,
                      write:      bus.ibus_write};
  assign dbus_cmd = '{address:    bus.dbus_address,
                      byteenable: bus.dbus_byteenable,
                      wrdata:     bus.dbus_wrdata,
                      read:       bus.dbus_read & ~bus.dbus_write,
                      write:      bus.dbus_write};

  logic  pick_dbus;
  logic  timed_out;
  resp_t fin;

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    mem_d     = mem_q;
    cnt_d     = cnt_q;
    ibus_d    = '{rddata: ibus_q.rddata, done: 1'b0, error: 1'b0};
    dbus_d    = '{rddata: dbus_q.rddata, done: 1'b0, error: 1'b0};
    pick_dbus = 1'b0;
    timed_out = 1'b0;
    fin       = '0;

    unique case (state_q)
      IDLE: begin
        if (ibus_pending || dbus_pending) begin
          pick_dbus = dbus_pending && (!ibus_pending || last_q == GRANT_I);
          mem_d     = pick_dbus ? dbus_cmd : ibus_cmd;
          last_d    = pick_dbus ? GRANT_D : GRANT_I;
          cnt_d     = '0;
          state_d   = pick_dbus ? BUSY_D : BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        timed_out = TIMEOUT_EN && (cnt_q == CNT_LAST);
        if (bus.mem_ack || timed_out) begin
          // An ack arriving in the terminal cycle still wins over the timeout.
          fin.done   = 1'b1;
          fin.error  = ~bus.mem_ack;
          fin.rddata = (state_q == BUSY_I) ? ibus_q.rddata : dbus_q.rddata;
          if (mem_q.read) begin
            fin.rddata = bus.mem_ack ? bus.mem_rddata : ERROR_DATA;
          end
          mem_d.read  = 1'b0;
          mem_d.write = 1'b0;
          state_d     = RESP;
          if (state_q == BUSY_I) begin
            ibus_d = fin;
          end else begin
            dbus_d = fin;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      mem_q   <= '0;
      cnt_q   <= '0;
      ibus_q  <= '0;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      ibus_q  <= ibus_d;
      dbus_q  <= dbus_d;
    end
  end

  assign bus.mem_address    = mem_q.address;
  assign bus.mem_byteenable = mem_q.byteenable;
  assign bus.mem_wrdata     = mem_q.wrdata;
  assign bus.mem_read       = mem_q.read;
  assign bus.mem_write      = mem_q.write;

  // Stall is the only combinational output: a live request not yet marked done.
  assign bus.ibus_stall  = ibus_pending & ~ibus_q.done;
  assign bus.ibus_rddata = ibus_q.rddata;
  assign bus.ibus_error  = ibus_q.error;

  assign bus.dbus_stall  = dbus_pending & ~dbus_q.done;
  assign bus.dbus_rddata = dbus_q.rddata;
  assign bus.dbus_error  = dbus_q.error;

endmodule
